// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-memory store buffer.
// Entry layout and default sizing used by the responder and its FIFO.
package data_mem_responder_pkg;
  localparam int DEPTH_DEF = 4;
  localparam int AW_DEF    = 32;
  localparam int WAW       = AW_DEF - 2;

  typedef struct packed {
    logic [WAW-1:0] waddr;
    logic [31:0]    data;
  } sb_entry_t;
endpackage

// File: rtl/data_mem_responder_fifo.sv
// Circular store-buffer FIFO: storage, head/tail pointers and count.
// Pointers wrap naturally because DEPTH is a power of two.
module store_buffer_fifo
  import data_mem_responder_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  sb_entry_t     push_entry,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic [PW-1:0] head,
  output sb_entry_t     mem_q [DEPTH]
);

  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[tail_q] <= push_entry;
        tail_q        <= tail_q + PW'(1);
      end
      if (pop) begin
        head_q <= head_q + PW'(1);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign count = count_q;
  assign head  = head_q;

endmodule

// File: rtl/data_mem_responder.sv
// Store buffer in front of a data SRAM with load forwarding.
// Loads see buffered stores (youngest wins), never the store issued now.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MemWrite,
  input  logic [AW-1:0] ALUResult,
  input  logic [31:0]   WriteData,
  output logic [31:0]   ReadData,
  output logic          Stall,
  output logic          Empty,
  output logic          sram_wr_valid,
  input  logic          sram_wr_ready,
  output logic [AW-1:0] sram_wr_addr,
  output logic [31:0]   sram_wr_data,
  output logic [AW-1:0] sram_rd_addr,
  input  logic [31:0]   sram_rd_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0]  count;
  logic [PW-1:0]  head;
  sb_entry_t      mem [DEPTH];
  sb_entry_t      new_entry;
  sb_entry_t      head_e;
  logic [WAW-1:0] req_waddr;
  logic           full;
  logic           push;
  logic           pop;
  logic [PW-1:0]  idx;

  assign req_waddr = WAW'(ALUResult[AW-1:2]);
  assign new_entry = '{waddr: req_waddr, data: WriteData};

  // Full-check only: the SRAM handshake must not reach Stall.
  assign full          = (count == CW'(DEPTH));
  assign Stall         = MemWrite & full;
  assign push          = MemWrite & ~full;
  assign sram_wr_valid = (count != '0);
  assign pop           = sram_wr_valid & sram_wr_ready;
  assign Empty         = (count == '0);

  assign head_e       = mem[head];
  assign sram_wr_addr = AW'({head_e.waddr, 2'b00});
  assign sram_wr_data = head_e.data;
  assign sram_rd_addr = ALUResult;

  store_buffer_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_entry(new_entry),
    .pop       (pop),
    .count     (count),
    .head      (head),
    .mem_q     (mem)
  );

  // Scan oldest to youngest so the last hit is the youngest match.
  always_comb begin
    ReadData = sram_rd_data;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (mem[idx].waddr == req_waddr)) begin
        ReadData = mem[idx].data;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: vector table, corner sequences, random.
// A queue-based model of the store buffer supplies expected values.
module tb_data_mem_responder;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          MemWrite;
  logic [AW-1:0] ALUResult;
  logic [31:0]   WriteData;
  logic [31:0]   ReadData;
  logic          Stall;
  logic          Empty;
  logic          sram_wr_valid;
  logic          sram_wr_ready;
  logic [AW-1:0] sram_wr_addr;
  logic [31:0]   sram_wr_data;
  logic [AW-1:0] sram_rd_addr;
  logic [31:0]   sram_rd_data;

  data_mem_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .MemWrite     (MemWrite),
    .ALUResult    (ALUResult),
    .WriteData    (WriteData),
    .ReadData     (ReadData),
    .Stall        (Stall),
    .Empty        (Empty),
    .sram_wr_valid(sram_wr_valid),
    .sram_wr_ready(sram_wr_ready),
    .sram_wr_addr (sram_wr_addr),
    .sram_wr_data (sram_wr_data),
    .sram_rd_addr (sram_rd_addr),
    .sram_rd_data (sram_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        rdy;
    logic [31:0] rd;
    logic        e_stall;
    logic        e_empty;
    logic        e_valid;
    logic [31:0] e_rdata;
    logic [31:0] e_waddr;
    logic [31:0] e_wdata;
  } vec_t;

  wr_t q[$];
  wr_t obs[$];
  wr_t sent[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic rdy,
                       input logic [31:0] rd);
    MemWrite      = we;
    ALUResult     = a;
    WriteData     = wd;
    sram_wr_ready = rdy;
    sram_rd_data  = rd;
    #1;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0] r;
    r = rd;
    foreach (q[i]) begin
      if (q[i].a[31:2] == a[31:2]) r = q[i].d;
    end
    return r;
  endfunction

  task automatic check_model(input string tag);
    logic e_full;
    e_full = (q.size() == DEPTH);
    chk({tag, " stall"}, 32'(Stall), 32'(MemWrite & e_full));
    chk({tag, " empty"}, 32'(Empty), 32'(q.size() == 0));
    chk({tag, " valid"}, 32'(sram_wr_valid), 32'(q.size() != 0));
    chk({tag, " rdata"}, ReadData, model_read(ALUResult, sram_rd_data));
    chk({tag, " rdaddr"}, sram_rd_addr, ALUResult);
    if (q.size() != 0) begin
      chk({tag, " waddr"}, sram_wr_addr, {q[0].a[31:2], 2'b00});
      chk({tag, " wdata"}, sram_wr_data, q[0].d);
    end
  endtask

  task automatic clock_edge();
    logic do_pop;
    logic do_push;
    wr_t  e;
    do_pop  = (q.size() != 0) && sram_wr_ready;
    do_push = MemWrite && (q.size() < DEPTH);
    if (sram_wr_valid && sram_wr_ready) begin
      e.a = sram_wr_addr;
      e.d = sram_wr_data;
      obs.push_back(e);
    end
    e.a = ALUResult;
    e.d = WriteData;
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(e);
    @(negedge clk);
  endtask

  task automatic step(input logic we, input logic [31:0] a,
                      input logic [31:0] wd, input logic rdy,
                      input logic [31:0] rd, input string tag);
    drive(we, a, wd, rdy, rd);
    check_model(tag);
    clock_edge();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 32'h0000_0100, 32'h1234_5678, 1'b1, 32'h0);
    chk("rst stall", 32'(Stall), 32'd0);
    chk("rst empty", 32'(Empty), 32'd1);
    chk("rst valid", 32'(sram_wr_valid), 32'd0);
    chk("rst waddr", sram_wr_addr, 32'd0);
    chk("rst wdata", sram_wr_data, 32'd0);
    @(posedge clk);
    #1;
    chk("rst edge empty", 32'(Empty), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  vec_t vt[18];

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    vt[0]  = '{0, 32'h1000, 32'h0, 0, 32'h55, 0, 1, 0, 32'h55, 0, 0};
    vt[1]  = '{1, 32'h1000, 32'hDEADBEEF, 0, 32'h11, 0, 1, 0, 32'h11, 0, 0};
    vt[2]  = '{0, 32'h1000, 32'h0, 0, 32'h22, 0, 0, 1, 32'hDEADBEEF,
               32'h1000, 32'hDEADBEEF};
    vt[3]  = '{1, 32'h20, 32'h1, 0, 32'h33, 0, 0, 1, 32'h33,
               32'h1000, 32'hDEADBEEF};
    vt[4]  = '{1, 32'h20, 32'h2, 0, 32'h44, 0, 0, 1, 32'h1,
               32'h1000, 32'hDEADBEEF};
    vt[5]  = '{0, 32'h20, 32'h0, 0, 32'h45, 0, 0, 1, 32'h2,
               32'h1000, 32'hDEADBEEF};
    vt[6]  = '{0, 32'h24, 32'h0, 0, 32'h66, 0, 0, 1, 32'h66,
               32'h1000, 32'hDEADBEEF};
    vt[7]  = '{1, 32'h43, 32'hCAFE, 0, 32'h77, 0, 0, 1, 32'h77,
               32'h1000, 32'hDEADBEEF};
    vt[8]  = '{1, 32'h50, 32'h5, 1, 32'h88, 1, 0, 1, 32'h88,
               32'h1000, 32'hDEADBEEF};
    vt[9]  = '{1, 32'h50, 32'h5, 0, 32'h99, 0, 0, 1, 32'h99, 32'h20, 32'h1};
    vt[10] = '{0, 32'h41, 32'h0, 0, 32'h0, 0, 0, 1, 32'hCAFE, 32'h20, 32'h1};
    vt[11] = '{0, 32'h50, 32'h0, 0, 32'h0, 0, 0, 1, 32'h5, 32'h20, 32'h1};
    vt[12] = '{1, 32'h60, 32'h7, 0, 32'hAB, 1, 0, 1, 32'hAB, 32'h20, 32'h1};
    vt[13] = '{0, 32'h0, 32'h0, 1, 32'hC0, 0, 0, 1, 32'hC0, 32'h20, 32'h1};
    vt[14] = '{0, 32'h20, 32'h0, 1, 32'h0, 0, 0, 1, 32'h2, 32'h20, 32'h2};
    vt[15] = '{0, 32'h0, 32'h0, 1, 32'hC1, 0, 0, 1, 32'hC1,
               32'h40, 32'hCAFE};
    vt[16] = '{0, 32'h0, 32'h0, 1, 32'hC2, 0, 0, 1, 32'hC2, 32'h50, 32'h5};
    vt[17] = '{0, 32'h0, 32'h0, 1, 32'hC3, 0, 1, 0, 32'hC3, 0, 0};

    do_reset();

    for (int i = 0; i < 18; i++) begin
      drive(vt[i].we, vt[i].addr, vt[i].wd, vt[i].rdy, vt[i].rd);
      chk($sformatf("vec%0d stall", i), 32'(Stall), 32'(vt[i].e_stall));
      chk($sformatf("vec%0d empty", i), 32'(Empty), 32'(vt[i].e_empty));
      chk($sformatf("vec%0d valid", i), 32'(sram_wr_valid),
          32'(vt[i].e_valid));
      chk($sformatf("vec%0d rdata", i), ReadData, vt[i].e_rdata);
      if (vt[i].e_valid) begin
        chk($sformatf("vec%0d waddr", i), sram_wr_addr, vt[i].e_waddr);
        chk($sformatf("vec%0d wdata", i), sram_wr_data, vt[i].e_wdata);
      end
      check_model($sformatf("vec%0d model", i));
      clock_edge();
    end

    // Ten stores with toggling ready; a stalled store is re-presented.
    obs.delete();
    sent.delete();
    begin
      int k;
      int cyc;
      k   = 0;
      cyc = 0;
      while (k < 10 && cyc < 100) begin
        wr_t e;
        e.a = 32'h100 + 32'(4 * k);
        e.d = 32'h1111 * 32'(k) + 32'h7;
        drive(1'b1, e.a, e.d, cyc[0], $urandom);
        check_model("wrap");
        if (!Stall) begin
          sent.push_back(e);
          k++;
        end
        clock_edge();
        cyc++;
      end
      chk("wrap issue timeout", 32'(k), 32'd10);
      cyc = 0;
      while (q.size() != 0 && cyc < 20) begin
        step(1'b0, 32'h0, 32'h0, 1'b1, 32'h0, "wrap drain");
        cyc++;
      end
      chk("wrap drain timeout", 32'(q.size()), 32'd0);
      chk("wrap count", 32'(obs.size()), 32'd10);
      for (int i = 0; i < 10 && i < obs.size(); i++) begin
        chk($sformatf("wrap%0d addr", i), obs[i].a, sent[i].a);
        chk($sformatf("wrap%0d data", i), obs[i].d, sent[i].d);
      end
    end

    // Reset mid-drain drops buffered stores asynchronously.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h300 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0, 32'h0,
           "pre-rst");
    end
    drive(1'b0, 32'h300, 32'h0, 1'b1, 32'h0);
    chk("pre-rst valid", 32'(sram_wr_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid rst valid", 32'(sram_wr_valid), 32'd0);
    chk("mid rst empty", 32'(Empty), 32'd1);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    obs.delete();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 32'h300, 32'h0, 1'b1, 32'h5A, "post-rst");
    end
    chk("post-rst writes", 32'(obs.size()), 32'd0);

    // Random traffic over a small address window to provoke hits.
    obs.delete();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = 32'h200 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      step(1'($urandom), a, $urandom, 1'($urandom), $urandom, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
